// File: rtl/store_commit_queue.sv
// store_commit_queue: in-order store queue between the load/store unit and data memory.
// Stores are accepted with their address resolved, held until the ROB retires their tag,
// then drained to memory oldest first, one per cycle. A mispredict discards every
// entry that has not yet been retired.
//
// Optional feature: define STQ_FORWARD_EN for combinational store-to-load forwarding.
// Without it fwd_hit_o/fwd_data_o are tied to zero.
//
// Ports:
//   clk_i, reset_ni                  clock, asynchronous active-low reset
//   enq_*_i                          store from the execution unit (addr, data, funct3 width, ROB tag)
//   is_full_o, count_o               occupancy (registered)
//   enq_drop_o                       pulse: enqueue refused (full or flush)
//   commit_valid_i, commit_tag_i     ROB retirement of the store at the commit pointer
//   commit_err_o                     pulse: retirement tag mismatch or nothing to retire
//   mis_pred_i                       flush all unretired entries
//   dmem_*_o, misalign_o             registered memory write port, misaligned-drop pulse
//   ld_addr_i                        load probe address
//   fwd_hit_o, fwd_data_o            forwarding result (combinational)
//   ld_conflict_o                    combinational: a live entry targets ld_addr's word
module store_commit_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TAG_W = 6
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     enq_valid_i,
    input  logic [31:0]              enq_addr_i,
    input  logic [31:0]              enq_data_i,
    input  logic [2:0]               enq_width_i,
    input  logic [TAG_W-1:0]         enq_tag_i,
    output logic                     is_full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     enq_drop_o,
    input  logic                     commit_valid_i,
    input  logic [TAG_W-1:0]         commit_tag_i,
    output logic                     commit_err_o,
    input  logic                     mis_pred_i,
    output logic                     dmem_we_o,
    output logic [31:0]              dmem_write_addr_o,
    output logic [31:0]              dmem_write_data_o,
    output logic [3:0]               dmem_byte_en_o,
    output logic                     misalign_o,
    input  logic [31:0]              ld_addr_i,
    output logic                     fwd_hit_o,
    output logic [31:0]              fwd_data_o,
    output logic                     ld_conflict_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    localparam logic [2:0] W_SB = 3'b000;
    localparam logic [2:0] W_SH = 3'b001;
    localparam logic [2:0] W_SW = 3'b010;

    typedef struct packed {
        logic [31:0]      addr;
        logic [31:0]      data;
        logic [2:0]       width;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t mem_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] commit_q, commit_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             enq_drop_q, enq_drop_d;
    logic             commit_err_q, commit_err_d;
    logic             we_q, we_d;
    logic [31:0]      waddr_q, waddr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic             misalign_q, misalign_d;

    logic   enq_ok;
    logic   commit_ok;
    logic   drain;
    entry_t enq_entry;
    entry_t head_entry;
    entry_t commit_entry;

    assign head_entry   = mem_q[head_q[IDX_W-1:0]];
    assign commit_entry = mem_q[commit_q[IDX_W-1:0]];

    // Pointer update: commit is resolved before flush so a same-cycle retire survives.
    always_comb begin
        enq_ok       = 1'b0;
        commit_ok    = 1'b0;
        drain        = 1'b0;
        head_d       = head_q;
        commit_d     = commit_q;
        tail_d       = tail_q;
        enq_drop_d   = 1'b0;
        commit_err_d = 1'b0;

        enq_ok    = enq_valid_i && !full_q && !mis_pred_i;
        commit_ok = commit_valid_i && (commit_q != tail_q) &&
                    (commit_entry.tag == commit_tag_i);
        drain     = (head_q != commit_q);

        enq_drop_d   = enq_valid_i && !enq_ok;
        commit_err_d = commit_valid_i && !commit_ok;

        commit_d = commit_q + PTR_W'(commit_ok);
        head_d   = head_q + PTR_W'(drain);
        if (mis_pred_i) begin
            tail_d = commit_d;
        end else begin
            tail_d = tail_q + PTR_W'(enq_ok);
        end

        count_d = tail_d - head_d;
        full_d  = (count_d == PTR_W'(DEPTH));
    end

    // Lane steering of the head entry; misaligned or unknown widths write nothing.
    always_comb begin
        we_d       = 1'b0;
        waddr_d    = 32'h0;
        wdata_d    = 32'h0;
        be_d       = 4'h0;
        misalign_d = 1'b0;
        if (drain) begin
            waddr_d = {head_entry.addr[31:2], 2'b00};
            case (head_entry.width)
                W_SB: begin
                    we_d    = 1'b1;
                    be_d    = 4'(4'b0001 << head_entry.addr[1:0]);
                    wdata_d = {4{head_entry.data[7:0]}};
                end
                W_SH: begin
                    if (head_entry.addr[0]) begin
                        misalign_d = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        be_d    = head_entry.addr[1] ? 4'b1100 : 4'b0011;
                        wdata_d = {2{head_entry.data[15:0]}};
                    end
                end
                W_SW: begin
                    if (head_entry.addr[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        be_d    = 4'b1111;
                        wdata_d = head_entry.data;
                    end
                end
                default: misalign_d = 1'b1;
            endcase
        end
    end

    always_comb begin
        enq_entry       = '0;
        enq_entry.addr  = enq_addr_i;
        enq_entry.data  = enq_data_i;
        enq_entry.width = enq_width_i;
        enq_entry.tag   = enq_tag_i;
    end

    // Entry storage carries no reset; liveness is defined purely by the pointers.
    always_ff @(posedge clk_i) begin
        if (enq_ok) begin
            mem_q[tail_q[IDX_W-1:0]] <= enq_entry;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            head_q       <= '0;
            commit_q     <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            enq_drop_q   <= 1'b0;
            commit_err_q <= 1'b0;
            we_q         <= 1'b0;
            waddr_q      <= 32'h0;
            wdata_q      <= 32'h0;
            be_q         <= 4'h0;
            misalign_q   <= 1'b0;
        end else begin
            head_q       <= head_d;
            commit_q     <= commit_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            full_q       <= full_d;
            enq_drop_q   <= enq_drop_d;
            commit_err_q <= commit_err_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            misalign_q   <= misalign_d;
        end
    end

    // Word-granular conflict check over live entries (head .. tail-1).
    always_comb begin
        logic [IDX_W-1:0] idx;
        ld_conflict_o = 1'b0;
        idx           = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head_q[IDX_W-1:0] + IDX_W'(k);
            if ((PTR_W'(k) < count_q) && (mem_q[idx].addr[31:2] == ld_addr_i[31:2])) begin
                ld_conflict_o = 1'b1;
            end
        end
    end

`ifdef STQ_FORWARD_EN
    // Walk oldest to youngest so the youngest overlapping entry decides the result.
    always_comb begin
        logic [IDX_W-1:0] idx;
        fwd_hit_o  = 1'b0;
        fwd_data_o = 32'h0;
        idx        = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head_q[IDX_W-1:0] + IDX_W'(k);
            if ((PTR_W'(k) < count_q) && (mem_q[idx].addr[31:2] == ld_addr_i[31:2])) begin
                fwd_hit_o  = (mem_q[idx].width == W_SW) && (mem_q[idx].addr[1:0] == 2'b00);
                fwd_data_o = mem_q[idx].data;
            end
        end
    end
`else
    assign fwd_hit_o  = 1'b0;
    assign fwd_data_o = 32'h0;
`endif

    // Load probe is word-granular; byte offset is intentionally ignored.
    logic unused_ld_lsb;
    assign unused_ld_lsb = ^ld_addr_i[1:0];

    assign is_full_o         = full_q;
    assign count_o           = count_q;
    assign enq_drop_o        = enq_drop_q;
    assign commit_err_o      = commit_err_q;
    assign dmem_we_o         = we_q;
    assign dmem_write_addr_o = waddr_q;
    assign dmem_write_data_o = wdata_q;
    assign dmem_byte_en_o    = be_q;
    assign misalign_o        = misalign_q;

endmodule

// File: tb/tb_store_commit_queue.sv
// Directed self-checking bench for store_commit_queue (DEPTH 8, TAG_W 6).
module tb_store_commit_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TAG_W = 6;

    logic             clk;
    logic             reset_n;
    logic             enq_valid;
    logic [31:0]      enq_addr;
    logic [31:0]      enq_data;
    logic [2:0]       enq_width;
    logic [TAG_W-1:0] enq_tag;
    logic             is_full;
    logic [3:0]       count;
    logic             enq_drop;
    logic             commit_valid;
    logic [TAG_W-1:0] commit_tag;
    logic             commit_err;
    logic             mis_pred;
    logic             dmem_we;
    logic [31:0]      dmem_addr;
    logic [31:0]      dmem_data;
    logic [3:0]       dmem_be;
    logic             misalign;
    logic [31:0]      ld_addr;
    logic             fwd_hit;
    logic [31:0]      fwd_data;
    logic             ld_conflict;

    int checks = 0;
    int errors = 0;

    store_commit_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_i             (clk),
        .reset_ni          (reset_n),
        .enq_valid_i       (enq_valid),
        .enq_addr_i        (enq_addr),
        .enq_data_i        (enq_data),
        .enq_width_i       (enq_width),
        .enq_tag_i         (enq_tag),
        .is_full_o         (is_full),
        .count_o           (count),
        .enq_drop_o        (enq_drop),
        .commit_valid_i    (commit_valid),
        .commit_tag_i      (commit_tag),
        .commit_err_o      (commit_err),
        .mis_pred_i        (mis_pred),
        .dmem_we_o         (dmem_we),
        .dmem_write_addr_o (dmem_addr),
        .dmem_write_data_o (dmem_data),
        .dmem_byte_en_o    (dmem_be),
        .misalign_o        (misalign),
        .ld_addr_i         (ld_addr),
        .fwd_hit_o         (fwd_hit),
        .fwd_data_o        (fwd_data),
        .ld_conflict_o     (ld_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [2:0] w,
                       input logic [TAG_W-1:0] t);
        enq_valid = 1'b1;
        enq_addr  = a;
        enq_data  = d;
        enq_width = w;
        enq_tag   = t;
    endtask

    task automatic commit(input logic [TAG_W-1:0] t);
        commit_valid = 1'b1;
        commit_tag   = t;
    endtask

    task automatic idle();
        enq_valid    = 1'b0;
        commit_valid = 1'b0;
        mis_pred     = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        enq_valid    = 1'b0;
        enq_addr     = '0;
        enq_data     = '0;
        enq_width    = '0;
        enq_tag      = '0;
        commit_valid = 1'b0;
        commit_tag   = '0;
        mis_pred     = 1'b0;
        ld_addr      = 32'hFFFF_FFF0;

        // Reset state
        tick();
        tick();
        check("rst_count",      32'(count), 32'd0);
        check("rst_full",       32'(is_full), 32'd0);
        check("rst_we",         32'(dmem_we), 32'd0);
        check("rst_be",         32'(dmem_be), 32'd0);
        check("rst_drop",       32'(enq_drop), 32'd0);
        check("rst_cerr",       32'(commit_err), 32'd0);
        check("rst_misalign",   32'(misalign), 32'd0);
        reset_n = 1'b1;
        tick();

        // SW 0x100 retired and drained
        enq(32'h100, 32'hDEAD_BEEF, 3'b010, 6'd5);
        tick();
        idle();
        check("sw_count1", 32'(count), 32'd1);
        commit(6'd5);
        tick();
        idle();
        check("sw_cerr", 32'(commit_err), 32'd0);
        check("sw_we_early", 32'(dmem_we), 32'd0);
        tick();
        check("sw_we",    32'(dmem_we), 32'd1);
        check("sw_addr",  dmem_addr, 32'h100);
        check("sw_be",    32'(dmem_be), 32'hF);
        check("sw_data",  dmem_data, 32'hDEAD_BEEF);
        check("sw_count0", 32'(count), 32'd0);
        tick();
        check("sw_we_off", 32'(dmem_we), 32'd0);

        // SB lane steering then misaligned SH
        enq(32'h203, 32'h5A, 3'b000, 6'd1);
        tick();
        enq(32'h201, 32'h1234, 3'b001, 6'd2);
        tick();
        idle();
        commit(6'd1);
        tick();
        commit(6'd2);
        tick();
        idle();
        check("sb_we",   32'(dmem_we), 32'd1);
        check("sb_addr", dmem_addr, 32'h200);
        check("sb_be",   32'(dmem_be), 32'h8);
        check("sb_data", dmem_data, 32'h5A5A_5A5A);
        tick();
        check("sh_mis_we",  32'(dmem_we), 32'd0);
        check("sh_mis_be",  32'(dmem_be), 32'd0);
        check("sh_mis",     32'(misalign), 32'd1);
        tick();
        check("sh_mis_off", 32'(misalign), 32'd0);
        check("sh_count",   32'(count), 32'd0);

        // Fill to DEPTH, refused ninth enqueue, then flush everything unretired
        for (int i = 1; i <= 8; i++) begin
            enq(32'h300 + 32'(4 * i), 32'(i), 3'b010, 6'(i));
            tick();
        end
        check("fill_full",  32'(is_full), 32'd1);
        check("fill_count", 32'(count), 32'd8);
        enq(32'h340, 32'h9, 3'b010, 6'd9);
        tick();
        idle();
        check("fill_drop",   32'(enq_drop), 32'd1);
        check("fill_count9", 32'(count), 32'd8);
        tick();
        check("fill_drop_off", 32'(enq_drop), 32'd0);
        mis_pred = 1'b1;
        tick();
        idle();
        check("flush_count", 32'(count), 32'd0);
        check("flush_full",  32'(is_full), 32'd0);
        check("flush_we",    32'(dmem_we), 32'd0);

        // Retire tag 1 of three, then mispredict: only tag 1 reaches memory
        enq(32'h400, 32'hA1, 3'b010, 6'd1);
        tick();
        enq(32'h404, 32'hA2, 3'b010, 6'd2);
        tick();
        enq(32'h408, 32'hA3, 3'b010, 6'd3);
        tick();
        idle();
        commit(6'd1);
        tick();
        idle();
        mis_pred = 1'b1;
        tick();
        idle();
        check("mp_we",    32'(dmem_we), 32'd1);
        check("mp_addr",  dmem_addr, 32'h400);
        check("mp_data",  dmem_data, 32'hA1);
        check("mp_count", 32'(count), 32'd0);
        tick();
        check("mp_we_off1", 32'(dmem_we), 32'd0);
        tick();
        check("mp_we_off2", 32'(dmem_we), 32'd0);

        // Wrong retirement tag, then correct one
        enq(32'h500, 32'h33, 3'b010, 6'd3);
        tick();
        idle();
        commit(6'd7);
        tick();
        idle();
        check("ce_err",   32'(commit_err), 32'd1);
        check("ce_count", 32'(count), 32'd1);
        commit(6'd3);
        tick();
        idle();
        check("ce_err_off", 32'(commit_err), 32'd0);
        check("ce_no_we",   32'(dmem_we), 32'd0);
        tick();
        check("ce_we",   32'(dmem_we), 32'd1);
        check("ce_addr", dmem_addr, 32'h500);
        check("ce_data", dmem_data, 32'h33);
        commit(6'd3);
        tick();
        idle();
        check("ce_empty_err", 32'(commit_err), 32'd1);
        tick();
        check("ce_empty_off", 32'(commit_err), 32'd0);

        // Load probe: two SWs to 0x40, youngest wins
        enq(32'h40, 32'h11, 3'b010, 6'd1);
        tick();
        enq(32'h40, 32'h22, 3'b010, 6'd2);
        tick();
        idle();
        ld_addr = 32'h40;
        #1;
        check("ld_conf_40", 32'(ld_conflict), 32'd1);
`ifdef STQ_FORWARD_EN
        check("fwd_hit_40",  32'(fwd_hit), 32'd1);
        check("fwd_data_40", fwd_data, 32'h22);
`else
        check("fwd_hit_off",  32'(fwd_hit), 32'd0);
        check("fwd_data_off", fwd_data, 32'h0);
`endif
        ld_addr = 32'h44;
        #1;
        check("ld_conf_44", 32'(ld_conflict), 32'd0);
        check("fwd_hit_44", 32'(fwd_hit), 32'd0);
        ld_addr = 32'h42;
        #1;
        check("ld_conf_42", 32'(ld_conflict), 32'd1);
        mis_pred = 1'b1;
        tick();
        idle();
        ld_addr = 32'h40;
        #1;
        check("ld_conf_flushed", 32'(ld_conflict), 32'd0);
        check("ld_count",        32'(count), 32'd0);

        // Reset while a retired store awaits drain: the write is lost
        enq(32'h600, 32'h66, 3'b010, 6'd4);
        tick();
        idle();
        commit(6'd4);
        tick();
        idle();
        reset_n = 1'b0;
        #1;
        check("rd_count", 32'(count), 32'd0);
        check("rd_we",    32'(dmem_we), 32'd0);
        tick();
        check("rd_we_hold", 32'(dmem_we), 32'd0);
        reset_n = 1'b1;
        tick();
        check("rd_we_after", 32'(dmem_we), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
